// File: rtl/int_request_ctrl_if.sv
// Request/response bundle between the interrupt request controller and the core.
// The slave modport is the controller side; the master modport is the core/stimulus side.
interface int_request_ctrl_if #(
  parameter int PEND_W = 2
);
  logic              irq_in;
  logic              int_en;
  logic              int_ack;
  logic              rti_done;
  logic              clr_ovf;
  logic              interupt;
  logic              in_service;
  logic [PEND_W-1:0] pending_cnt;
  logic              overflow;

  modport master (
    output irq_in, int_en, int_ack, rti_done, clr_ovf,
    input  interupt, in_service, pending_cnt, overflow
  );

  modport slave (
    input  irq_in, int_en, int_ack, rti_done, clr_ovf,
    output interupt, in_service, pending_cnt, overflow
  );
endinterface

// File: rtl/int_request_ctrl.sv
// Interrupt request controller: edge capture, saturating pending count, held request to the core.
// Define INT_REQ_SYNC_EN to put a 2-flop synchronizer in front of the irq_in edge detect.
module int_request_ctrl #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  int_request_ctrl_if.slave bus
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

  state_t            state, state_nx;
  logic              irq_s, irq_prev, rise, accept, ovf_set;
  logic              interupt_q, in_service_q, overflow_q;
  logic [PEND_W-1:0] cnt_q;

`ifdef INT_REQ_SYNC_EN
  logic [1:0] irq_sync;
  always_ff @(posedge clk) begin
    if (reset) irq_sync <= '0;
    else       irq_sync <= {irq_sync[0], bus.irq_in};
  end
  assign irq_s = irq_sync[1];
`else
  assign irq_s = bus.irq_in;
`endif

  assign rise    = irq_s & ~irq_prev;
  assign accept  = (state == PEND) & bus.int_ack;
  // A rise paired with an accept nets to zero, so it can never overflow.
  assign ovf_set = rise & ~accept & (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if ((cnt_q != '0) && bus.int_en) state_nx = PEND;
      PEND:    if (bus.int_ack)                 state_nx = SERVICE;
      SERVICE: if (bus.rti_done)                state_nx = IDLE;
      default:                                  state_nx = IDLE;
    endcase
  end

  // Outputs are registered off the next state so the core sees clean levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev     <= 1'b0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      interupt_q   <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      irq_prev     <= irq_s;
      interupt_q   <= (state_nx == PEND);
      in_service_q <= (state_nx == SERVICE);
      overflow_q   <= ovf_set | (overflow_q & ~bus.clr_ovf);
      if (rise && !accept && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
      else if (accept && !rise)                  cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.interupt    = interupt_q;
  assign bus.in_service  = in_service_q;
  assign bus.pending_cnt = cnt_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_int_request_ctrl.sv
// Scoreboard bench for int_request_ctrl: a behavioural model queues expected outputs per cycle.
module tb_int_request_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  int_request_ctrl_if #(.PEND_W(2)) bus ();
  int_request_ctrl #(.PEND_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int i;
    int s;
    int c;
    int o;
  } exp_t;
  exp_t sb[$];

  // model state: 0 idle, 1 pend, 2 service
  int m_st = 0, m_cnt = 0, m_ovf = 0, m_prev = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int rise, acc, c, nst;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_ovf = 0; m_prev = 0;
    end else begin
      rise = (bus.irq_in && !m_prev) ? 1 : 0;
      acc  = (m_st == 1 && bus.int_ack) ? 1 : 0;
      nst  = m_st;
      if (m_st == 0 && m_cnt != 0 && bus.int_en) nst = 1;
      else if (m_st == 1 && bus.int_ack)         nst = 2;
      else if (m_st == 2 && bus.rti_done)        nst = 0;
      c = m_cnt + rise - acc;
      if (bus.clr_ovf) m_ovf = 0;
      if (c > 3) begin c = 3; m_ovf = 1; end
      m_cnt  = c;
      m_st   = nst;
      m_prev = bus.irq_in ? 1 : 0;
    end
    sb.push_back('{i: (m_st == 1), s: (m_st == 2), c: m_cnt, o: m_ovf});
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_int"}, bus.interupt,    e.i);
    chk({tag, "_svc"}, bus.in_service,  e.s);
    chk({tag, "_cnt"}, bus.pending_cnt, e.c);
    chk({tag, "_ovf"}, bus.overflow,    e.o);
  endtask

  task automatic pulse(input string tag);
    bus.irq_in = 1'b1; tick(tag);
    bus.irq_in = 1'b0; tick(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.irq_in = 0; bus.int_en = 0; bus.int_ack = 0; bus.rti_done = 0; bus.clr_ovf = 0;
    #1;
    tick("rst"); tick("rst");
    chk("rst_int", bus.interupt, 0);
    chk("rst_cnt", bus.pending_cnt, 0);
    reset = 1'b0;

    // basic dispatch: 2-cycle latency
    bus.int_en = 1;
    bus.irq_in = 1; tick("t1a");
    chk("t1_cnt1", bus.pending_cnt, 1);
    chk("t1_int0", bus.interupt, 0);
    tick("t1b");
    chk("t1_int1", bus.interupt, 1);
    bus.irq_in = 0; tick("t1c"); tick("t1d");
    bus.int_ack = 1; tick("t1ack"); bus.int_ack = 0;
    chk("t1_svc", bus.in_service, 1);
    chk("t1_cnt0", bus.pending_cnt, 0);
    chk("t1_intoff", bus.interupt, 0);

    // capture during service, redispatch after rti
    pulse("t2p"); pulse("t2p");
    chk("t2_cnt2", bus.pending_cnt, 2);
    chk("t2_int0", bus.interupt, 0);
    bus.rti_done = 1; tick("t2rti"); bus.rti_done = 0;
    chk("t2_svcoff", bus.in_service, 0);
    chk("t2_int_gap", bus.interupt, 0);
    tick("t2w");
    chk("t2_int1", bus.interupt, 1);
    bus.int_ack = 1; tick("t2ack"); bus.int_ack = 0;
    chk("t2_cnt1", bus.pending_cnt, 1);
    bus.rti_done = 1; tick("t2r2"); bus.rti_done = 0;
    tick("t2w2");
    bus.int_ack = 1; tick("t2a2"); bus.int_ack = 0;
    bus.rti_done = 1; tick("t2r3"); bus.rti_done = 0;

    // saturation with dispatch disabled
    bus.int_en = 0;
    pulse("t3"); pulse("t3"); pulse("t3"); pulse("t3");
    chk("t3_cnt3", bus.pending_cnt, 3);
    chk("t3_ovf1", bus.overflow, 1);
    chk("t3_int0", bus.interupt, 0);
    bus.clr_ovf = 1; tick("t3clr"); bus.clr_ovf = 0;
    chk("t3_ovf0", bus.overflow, 0);
    chk("t3_cntk", bus.pending_cnt, 3);

    // rise + accept at max: no change, no overflow
    bus.int_en = 1; tick("t4pend");
    bus.irq_in = 1; bus.int_ack = 1; tick("t4both");
    bus.irq_in = 0; bus.int_ack = 0;
    chk("t4_cnt3", bus.pending_cnt, 3);
    chk("t4_ovf0", bus.overflow, 0);

    // stray ack in idle, stray rti in pend, int_en drop in pend
    bus.rti_done = 1; tick("t5rti"); bus.rti_done = 0;
    bus.int_en = 0;
    bus.int_ack = 1; tick("t5sack"); bus.int_ack = 0;
    chk("t5_idle_cnt", bus.pending_cnt, 3);
    chk("t5_idle_svc", bus.in_service, 0);
    bus.int_en = 1; tick("t5pend");
    bus.rti_done = 1; tick("t5srti"); bus.rti_done = 0;
    chk("t5_pend_int", bus.interupt, 1);
    bus.int_en = 0; tick("t5hold"); tick("t5hold");
    chk("t5_hold_int", bus.interupt, 1);
    bus.int_ack = 1; tick("t5ack"); bus.int_ack = 0;
    chk("t5_cnt2", bus.pending_cnt, 2);

    // reset mid-service
    reset = 1; tick("t6rst"); reset = 0;
    chk("t6_cnt", bus.pending_cnt, 0);
    chk("t6_svc", bus.in_service, 0);

    // clr_ovf and new overflow together: set wins
    pulse("t7"); pulse("t7"); pulse("t7");
    bus.irq_in = 1; bus.clr_ovf = 1; tick("t7both");
    bus.irq_in = 0; bus.clr_ovf = 0;
    chk("t7_ovf", bus.overflow, 1);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.irq_in   = $urandom_range(0, 1);
      bus.int_en   = ($urandom_range(0, 3) != 0);
      bus.int_ack  = ($urandom_range(0, 3) == 0);
      bus.rti_done = ($urandom_range(0, 3) == 0);
      bus.clr_ovf  = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 63) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
